// File: rtl/delta_demod.sv
// Adaptive delta-modulation decoder: integrates up/down bits with a step size that grows on runs and shrinks on reversals.
// Optional PWM rendering of the reconstructed sample is enabled by defining DELTA_DEMOD_PWM_EN.
module delta_demod #(
  parameter int WIDTH    = 8,
  parameter int STEP_MIN = 1,
  parameter int STEP_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clr,
  output logic [WIDTH-1:0] sample,
  output logic             sample_valid,
  output logic [WIDTH-1:0] step,
  output logic             sat_flag,
  output logic             pwm_out
);

  localparam logic [WIDTH-1:0] C_MID      = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] C_STEP_MIN = WIDTH'(STEP_MIN);
  localparam logic [WIDTH:0]   C_STEP_MAX = (WIDTH+1)'(STEP_MAX);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_step;
  logic [1:0]       r_hist;
  logic [1:0]       r_hcnt;
  logic             r_sat;
  logic             r_sv;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_dbl;
  logic [WIDTH-1:0] w_half;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_step_next;
  logic             w_sat_next;
  logic [1:0]       w_hcnt_next;

  always_comb begin
    w_sum       = {1'b0, r_acc} + {1'b0, r_step};
    w_diff      = {1'b0, r_acc} - {1'b0, r_step};
    w_dbl       = {r_step, 1'b0};
    w_half      = r_step >> 1;
    w_acc_next  = r_acc;
    w_sat_next  = r_sat;
    w_step_next = r_step;
    w_hcnt_next = (r_hcnt == 2'd2) ? 2'd2 : r_hcnt + 2'd1;

    // The carry/borrow bit of the widened result flags a clamp.
    if (bit_in) begin
      if (w_sum[WIDTH]) begin
        w_acc_next = {WIDTH{1'b1}};
        w_sat_next = 1'b1;
      end else begin
        w_acc_next = w_sum[WIDTH-1:0];
      end
    end else begin
      if (w_diff[WIDTH]) begin
        w_acc_next = '0;
        w_sat_next = 1'b1;
      end else begin
        w_acc_next = w_diff[WIDTH-1:0];
      end
    end

    // r_hist[0] is the previous accepted bit, r_hist[1] the one before it.
    if (r_hcnt == 2'd2 && bit_in == r_hist[0] && bit_in == r_hist[1]) begin
      w_step_next = (w_dbl > C_STEP_MAX) ? C_STEP_MAX[WIDTH-1:0] : w_dbl[WIDTH-1:0];
    end else if (r_hcnt != 2'd0 && bit_in != r_hist[0]) begin
      w_step_next = (w_half < C_STEP_MIN) ? C_STEP_MIN : w_half;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= C_MID;
      r_step <= C_STEP_MIN;
      r_hist <= 2'b00;
      r_hcnt <= 2'd0;
      r_sat  <= 1'b0;
      r_sv   <= 1'b0;
    end else if (clr) begin
      r_acc  <= C_MID;
      r_step <= C_STEP_MIN;
      r_hist <= 2'b00;
      r_hcnt <= 2'd0;
      r_sat  <= 1'b0;
      r_sv   <= 1'b0;
    end else begin
      r_sv <= bit_valid;
      if (bit_valid) begin
        r_acc  <= w_acc_next;
        r_step <= w_step_next;
        r_hist <= {r_hist[0], bit_in};
        r_hcnt <= w_hcnt_next;
        r_sat  <= w_sat_next;
      end
    end
  end

  assign sample       = r_acc;
  assign sample_valid = r_sv;
  assign step         = r_step;
  assign sat_flag     = r_sat;

`ifdef DELTA_DEMOD_PWM_EN
  logic [WIDTH-1:0] r_pwm_cnt;
  logic             r_pwm;

  // Registered compare keeps pwm_out low during reset; duty over any full counter period is sample/2^WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_cnt <= '0;
      r_pwm     <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_pwm     <= (r_pwm_cnt < r_acc);
    end
  end

  assign pwm_out = r_pwm;
`else
  assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_delta_demod.sv
// Directed plus randomized bench for delta_demod against a list-of-accepted-bits reference model.
module tb_delta_demod;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] sample;
  logic       sample_valid;
  logic [7:0] step;
  logic       sat_flag;
  logic       pwm_out;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int m_acc, m_step, m_sat, m_sv;
  int m_bits[$];

  delta_demod #(.WIDTH(8), .STEP_MIN(1), .STEP_MAX(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .bit_valid    (bit_valid),
    .bit_in       (bit_in),
    .clr          (clr),
    .sample       (sample),
    .sample_valid (sample_valid),
    .step         (step),
    .sat_flag     (sat_flag),
    .pwm_out      (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    m_acc  = 128;
    m_step = 1;
    m_sat  = 0;
    m_sv   = 0;
    m_bits.delete();
  endtask

  task automatic model_bit(input int b);
    int nstep;
    int n;
    nstep = m_step;
    n = m_bits.size();
    if (n >= 2 && b == m_bits[n-1] && b == m_bits[n-2])
      nstep = (m_step * 2 > 16) ? 16 : m_step * 2;
    else if (n >= 1 && b != m_bits[n-1])
      nstep = (m_step / 2 < 1) ? 1 : m_step / 2;
    m_acc = b ? m_acc + m_step : m_acc - m_step;
    if (m_acc > 255) begin m_acc = 255; m_sat = 1; end
    if (m_acc < 0)   begin m_acc = 0;   m_sat = 1; end
    m_step = nstep;
    m_bits.push_back(b);
    if (m_bits.size() > 2) void'(m_bits.pop_front());
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sample"}, sample, m_acc);
    chk({tag, ".step"}, step, m_step);
    chk({tag, ".sample_valid"}, sample_valid, m_sv);
    chk({tag, ".sat_flag"}, sat_flag, m_sat);
`ifndef DELTA_DEMOD_PWM_EN
    chk({tag, ".pwm_out"}, pwm_out, 0);
`endif
  endtask

  // One clock: drive inputs, update model at the edge, check 1 time unit later.
  task automatic cyc(input string tag, input bit v, input bit b, input bit c);
    bit_valid = v;
    bit_in    = b;
    clr       = c;
    @(posedge clk);
    if (c) model_init();
    else if (v) model_bit(b);
    m_sv = (v && !c) ? 1 : 0;
    #1;
    check_all(tag);
    bit_valid = 1'b0;
    clr       = 1'b0;
  endtask

  // "a,a,~a" starting from step 1 with last bit ~a moves acc by one unit net, leaving step at 1.
  task automatic triples(input int n, input bit a);
    for (int i = 0; i < n; i++) begin
      cyc("triple", 1'b1, a, 1'b0);
      cyc("triple", 1'b1, a, 1'b0);
      cyc("triple", 1'b1, ~a, 1'b0);
    end
  endtask

  task automatic run(input int n, input bit b);
    for (int i = 0; i < n; i++) cyc("run", 1'b1, b, 1'b0);
  endtask

  initial begin
    int exp_s[5];
    int exp_st[5];
    int highs;
    int r;
    exp_s  = '{129, 130, 131, 133, 137};
    exp_st = '{1, 1, 2, 4, 8};
    model_init();

    repeat (3) @(posedge clk);
    #1;
    chk("in_reset.sample", sample, 128);
    chk("in_reset.step", step, 1);
    chk("in_reset.sat_flag", sat_flag, 0);
    chk("in_reset.sample_valid", sample_valid, 0);
    chk("in_reset.pwm_out", pwm_out, 0);
    rst = 1'b0;

    cyc("idle_after_reset", 1'b0, 1'b0, 1'b0);
    chk("idle.sample", sample, 128);

    for (int i = 0; i < 5; i++) begin
      cyc("ones", 1'b1, 1'b1, 1'b0);
      chk("ones.sample_const", sample, exp_s[i]);
      chk("ones.step_const", step, exp_st[i]);
    end
    cyc("zero", 1'b1, 1'b0, 1'b0);
    chk("zero.sample_const", sample, 129);
    chk("zero.step_const", step, 4);
    cyc("zero_idle", 1'b0, 1'b0, 1'b0);
    chk("zero_idle.sv_const", sample_valid, 0);

    // Saturation: reach acc=250/step=16, then one more up-step clamps.
    cyc("clr1", 1'b0, 1'b0, 1'b1);
    triples(9, 1'b1);
    run(12, 1'b1);
    chk("pre_sat.sample_const", sample, 250);
    chk("pre_sat.step_const", step, 16);
    cyc("sat", 1'b1, 1'b1, 1'b0);
    chk("sat.sample_const", sample, 255);
    chk("sat.flag_const", sat_flag, 1);
    run(4, 1'b0);
    chk("sat_sticky", sat_flag, 1);
    cyc("clr2", 1'b0, 1'b0, 1'b1);
    chk("clr2.sat_flag", sat_flag, 0);

    // clr wins over a simultaneous bit at sample=200.
    triples(7, 1'b1);
    run(9, 1'b1);
    chk("pre_clr.sample_const", sample, 200);
    cyc("clr_vs_bit", 1'b1, 1'b1, 1'b1);
    chk("clr_vs_bit.sample", sample, 128);
    chk("clr_vs_bit.step", step, 1);
    chk("clr_vs_bit.sv", sample_valid, 0);
    cyc("after_clr", 1'b0, 1'b0, 1'b0);

    // Hold sample=64 for one full PWM period.
    cyc("clr3", 1'b0, 1'b0, 1'b1);
    triples(15, 1'b0);
    run(8, 1'b0);
    chk("pwm_setup.sample_const", sample, 64);
    repeat (2) cyc("pwm_settle", 1'b0, 1'b0, 1'b0);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      cyc("pwm_hold", 1'b0, 1'b0, 1'b0);
      if (pwm_out === 1'b1) highs++;
    end
`ifdef DELTA_DEMOD_PWM_EN
    chk("pwm_high_cycles", highs, 64);
`else
    chk("pwm_high_cycles", highs, 0);
`endif

    // Random stream with occasional clr and mid-stream asynchronous reset.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst = 1'b1;
        #1;
        model_init();
        check_all("async_rst");
        chk("async_rst.pwm_out", pwm_out, 0);
        #2;
        rst = 1'b0;
      end else begin
        cyc("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1), (r < 5));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
